// File: rtl/roi_image_loader.sv
// Streams a raster frame from an FWFT input FIFO into image BRAM and forwards pixels inside a
// latched region of interest to the output FIFO. Optional macro: ROI_LOADER_ROI_COUNT_EN.
module roi_image_loader #(
  parameter int unsigned WIDTH      = 1280,
  parameter int unsigned HEIGHT     = 720,
  parameter int unsigned PIXEL_BITS = 24,
  parameter int unsigned ADDR_BITS  = $clog2(WIDTH * HEIGHT)
) (
  input  logic                                  clock,
  input  logic                                  reset,
  input  logic [$clog2(WIDTH)-1:0]              roi_x0,
  input  logic [$clog2(WIDTH)-1:0]              roi_x1,
  input  logic [$clog2(HEIGHT)-1:0]             roi_y0,
  input  logic [$clog2(HEIGHT)-1:0]             roi_y1,
  output logic                                  in_rd_en,
  input  logic                                  in_empty,
  input  logic [PIXEL_BITS-1:0]                 in_dout,
  output logic                                  fifo_out_wr_en,
  input  logic                                  fifo_out_full,
  output logic [PIXEL_BITS-1:0]                 fifo_out_din,
  output logic                                  fifo_out_last,
  output logic                                  bram_out_wr_en,
  output logic [ADDR_BITS-1:0]                  bram_out_wr_addr,
  output logic [PIXEL_BITS-1:0]                 bram_out_wr_data,
  output logic                                  load_finished,
  output logic [15:0]                           frame_count,
  output logic [$clog2(WIDTH*HEIGHT+1)-1:0]     roi_count
);

  localparam int unsigned XB = $clog2(WIDTH);
  localparam int unsigned YB = $clog2(HEIGHT);

  localparam logic StIdle = 1'b0;
  localparam logic StLoad = 1'b1;

  localparam logic [XB-1:0] XLast = XB'(WIDTH - 1);
  localparam logic [YB-1:0] YLast = YB'(HEIGHT - 1);

  logic                 state_q, state_d;
  logic [XB-1:0]        x_q, x_d;
  logic [YB-1:0]        y_q, y_d;
  logic [ADDR_BITS-1:0] addr_q, addr_d;
  logic [15:0]          frame_count_q, frame_count_d;
  logic [XB-1:0]        rx0_q, rx0_d, rx1_q, rx1_d;
  logic [YB-1:0]        ry0_q, ry0_d, ry1_q, ry1_d;

  logic in_roi;
  logic transfer;
  logic last_pixel;
  logic frame_start;

  // Inverted bounds make in_roi unsatisfiable, so no special case is needed.
  assign in_roi = (state_q == StLoad) &&
                  (x_q >= rx0_q) && (x_q <= rx1_q) &&
                  (y_q >= ry0_q) && (y_q <= ry1_q);

  // Only ROI pixels wait on the output FIFO; the rest flow straight to BRAM.
  assign transfer    = (state_q == StLoad) && !reset && !in_empty && !(in_roi && fifo_out_full);
  assign last_pixel  = (x_q == XLast) && (y_q == YLast);
  assign frame_start = (state_q == StIdle) && !in_empty;

  always_comb begin
    state_d       = state_q;
    x_d           = x_q;
    y_d           = y_q;
    addr_d        = addr_q;
    frame_count_d = frame_count_q;
    rx0_d         = rx0_q;
    rx1_d         = rx1_q;
    ry0_d         = ry0_q;
    ry1_d         = ry1_q;
    if (frame_start) begin
      state_d = StLoad;
      rx0_d   = roi_x0;
      rx1_d   = roi_x1;
      ry0_d   = roi_y0;
      ry1_d   = roi_y1;
      x_d     = '0;
      y_d     = '0;
      addr_d  = '0;
    end else if (transfer) begin
      addr_d = addr_q + ADDR_BITS'(1);
      if (x_q == XLast) begin
        x_d = '0;
        if (y_q == YLast) begin
          y_d           = '0;
          addr_d        = '0;
          state_d       = StIdle;
          frame_count_d = frame_count_q + 16'd1;
        end else begin
          y_d = y_q + YB'(1);
        end
      end else begin
        x_d = x_q + XB'(1);
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q       <= StIdle;
      x_q           <= '0;
      y_q           <= '0;
      addr_q        <= '0;
      frame_count_q <= '0;
      rx0_q         <= '0;
      rx1_q         <= '0;
      ry0_q         <= '0;
      ry1_q         <= '0;
    end else begin
      state_q       <= state_d;
      x_q           <= x_d;
      y_q           <= y_d;
      addr_q        <= addr_d;
      frame_count_q <= frame_count_d;
      rx0_q         <= rx0_d;
      rx1_q         <= rx1_d;
      ry0_q         <= ry0_d;
      ry1_q         <= ry1_d;
    end
  end

  always_comb begin
    in_rd_en         = transfer;
    bram_out_wr_en   = transfer;
    bram_out_wr_addr = transfer ? addr_q : '0;
    bram_out_wr_data = transfer ? in_dout : '0;
    fifo_out_wr_en   = transfer && in_roi;
    fifo_out_din     = (transfer && in_roi) ? in_dout : '0;
    fifo_out_last    = transfer && in_roi && (x_q == rx1_q) && (y_q == ry1_q);
    load_finished    = transfer && last_pixel;
  end

  assign frame_count = frame_count_q;

`ifdef ROI_LOADER_ROI_COUNT_EN
  localparam int unsigned CB = $clog2(WIDTH * HEIGHT + 1);

  logic [CB-1:0] roi_count_q;

  // Holds the final tally through IDLE until the next frame starts.
  always_ff @(posedge clock) begin
    if (reset) begin
      roi_count_q <= '0;
    end else if (frame_start) begin
      roi_count_q <= '0;
    end else if (fifo_out_wr_en) begin
      roi_count_q <= roi_count_q + CB'(1);
    end
  end

  assign roi_count = roi_count_q;
`else
  assign roi_count = '0;
`endif

endmodule

// File: tb/tb_roi_image_loader.sv
// Bench for roi_image_loader on an 8x4 frame: per-cycle model check plus directed literals.
`timescale 1ns/1ps
module tb_roi_image_loader;

  localparam int W = 8;
  localparam int H = 4;
  localparam int N = W * H;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [2:0]  roi_x0, roi_x1;
  logic [1:0]  roi_y0, roi_y1;
  logic        in_rd_en;
  logic        in_empty;
  logic [23:0] in_dout;
  logic        fifo_out_wr_en;
  logic        fifo_out_full;
  logic [23:0] fifo_out_din;
  logic        fifo_out_last;
  logic        bram_out_wr_en;
  logic [4:0]  bram_out_wr_addr;
  logic [23:0] bram_out_wr_data;
  logic        load_finished;
  logic [15:0] frame_count;
  logic [5:0]  roi_count;

  always #5 clock = ~clock;

  roi_image_loader #(
    .WIDTH     (W),
    .HEIGHT    (H),
    .PIXEL_BITS(24)
  ) dut (
    .clock           (clock),
    .reset           (reset),
    .roi_x0          (roi_x0),
    .roi_x1          (roi_x1),
    .roi_y0          (roi_y0),
    .roi_y1          (roi_y1),
    .in_rd_en        (in_rd_en),
    .in_empty        (in_empty),
    .in_dout         (in_dout),
    .fifo_out_wr_en  (fifo_out_wr_en),
    .fifo_out_full   (fifo_out_full),
    .fifo_out_din    (fifo_out_din),
    .fifo_out_last   (fifo_out_last),
    .bram_out_wr_en  (bram_out_wr_en),
    .bram_out_wr_addr(bram_out_wr_addr),
    .bram_out_wr_data(bram_out_wr_data),
    .load_finished   (load_finished),
    .frame_count     (frame_count),
    .roi_count       (roi_count)
  );

  int checks = 0;
  int errors = 0;

  // Input FIFO contents as one continuous pixel stream.
  logic [23:0] src [0:511];
  int  src_wp = 0;
  int  src_rp = 0;
  bit  gap_en = 1'b0;

  // Model state: frame progress as a plain pixel index.
  bit          m_busy = 1'b0;
  int          m_n = 0;
  int          m_rd = 0;
  int          m_rx0 = 0, m_rx1 = 0, m_ry0 = 0, m_ry1 = 0;
  logic [15:0] m_fc = '0;
  int          m_rc = 0;

  int          wr_total = 0;
  int          fin_total = 0;
  int          push_total = 0;
  logic [23:0] push_data [$];
  bit          push_last [$];

  int exp0 [8] = '{10, 11, 12, 13, 18, 19, 20, 21};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive();
    in_dout  = src[9'(src_rp)];
    in_empty = (src_rp >= src_wp) || (gap_en && ($urandom_range(1, 0) == 1));
  endtask

  task automatic compare();
    int x, y;
    bit roi, tr;
    if (reset) begin
      check("rst_rd_en",     32'(in_rd_en), 32'(0));
      check("rst_bram_wr",   32'(bram_out_wr_en), 32'(0));
      check("rst_bram_addr", 32'(bram_out_wr_addr), 32'(0));
      check("rst_bram_data", 32'(bram_out_wr_data), 32'(0));
      check("rst_fifo_wr",   32'(fifo_out_wr_en), 32'(0));
      check("rst_fifo_din",  32'(fifo_out_din), 32'(0));
      check("rst_fifo_last", 32'(fifo_out_last), 32'(0));
      check("rst_finished",  32'(load_finished), 32'(0));
      m_busy = 1'b0;
      m_fc   = '0;
      m_rc   = 0;
      return;
    end
    check("frame_count", 32'(frame_count), 32'(m_fc));
`ifdef ROI_LOADER_ROI_COUNT_EN
    check("roi_count", 32'(roi_count), 32'(m_rc));
`else
    check("roi_count", 32'(roi_count), 32'(0));
`endif
    if (!m_busy) begin
      check("idle_rd_en",   32'(in_rd_en), 32'(0));
      check("idle_bram_wr", 32'(bram_out_wr_en), 32'(0));
      check("idle_fifo_wr", 32'(fifo_out_wr_en), 32'(0));
      check("idle_finished", 32'(load_finished), 32'(0));
      if (!in_empty) begin
        m_busy = 1'b1;
        m_n    = 0;
        m_rc   = 0;
        m_rx0  = int'(roi_x0);
        m_rx1  = int'(roi_x1);
        m_ry0  = int'(roi_y0);
        m_ry1  = int'(roi_y1);
      end
    end else begin
      x   = m_n % W;
      y   = m_n / W;
      roi = (x >= m_rx0) && (x <= m_rx1) && (y >= m_ry0) && (y <= m_ry1);
      tr  = !in_empty && !(roi && fifo_out_full);
      check("rd_en",         32'(in_rd_en), 32'(tr));
      check("bram_wr_en",    32'(bram_out_wr_en), 32'(tr));
      check("fifo_wr_en",    32'(fifo_out_wr_en), 32'(tr && roi));
      check("load_finished", 32'(load_finished), 32'(tr && (m_n == N - 1)));
      if (tr) begin
        check("bram_addr", 32'(bram_out_wr_addr), 32'(m_n));
        check("bram_data", 32'(bram_out_wr_data), 32'(src[9'(m_rd)]));
        if (roi) begin
          check("fifo_din",  32'(fifo_out_din), 32'(src[9'(m_rd)]));
          check("fifo_last", 32'(fifo_out_last), 32'((x == m_rx1) && (y == m_ry1)));
          push_data.push_back(fifo_out_din);
          push_last.push_back(fifo_out_last);
          push_total++;
          m_rc++;
        end else begin
          check("fifo_last_off", 32'(fifo_out_last), 32'(0));
        end
        wr_total++;
        m_rd++;
        m_n++;
        if (m_n == N) begin
          m_busy = 1'b0;
          m_fc++;
          fin_total++;
        end
      end
    end
  endtask

  task automatic tick();
    bit rd;
    @(negedge clock);
    compare();
    rd = in_rd_en;
    @(posedge clock);
    #1;
    if (rd) src_rp++;
    drive();
  endtask

  task automatic push_frame(input int tag, input int count);
    for (int i = 0; i < count; i++) begin
      src[9'(src_wp)] = 24'(tag * 256 + i);
      src_wp++;
    end
    drive();
  endtask

  task automatic set_roi(input int x0, input int x1, input int y0, input int y1);
    roi_x0 = 3'(x0);
    roi_x1 = 3'(x1);
    roi_y0 = 2'(y0);
    roi_y1 = 2'(y1);
  endtask

  task automatic wait_fin(input int target, input int budget, input string name,
                          output int cycles);
    cycles = 0;
    while (fin_total < target && cycles < budget) begin
      tick();
      cycles++;
    end
    check(name, 32'(fin_total >= target), 32'(1));
  endtask

  initial begin
    int base_push, base_wr, mid, cyc, lasts;
    set_roi(0, 0, 0, 0);
    in_empty      = 1'b1;
    in_dout       = '0;
    fifo_out_full = 1'b0;
    reset         = 1'b1;
    repeat (3) tick();
    reset = 1'b0;
    #1;
    check("post_reset_frame_count", 32'(frame_count), 32'(0));
    check("post_reset_rd_en", 32'(in_rd_en), 32'(0));

    // Frame 0: ROI columns 2..5, rows 1..2, no stalls.
    set_roi(2, 5, 1, 2);
    base_push = push_total;
    push_frame(0, N);
    wait_fin(1, 80, "f0_done", cyc);
    check("f0_cycles", 32'(cyc), 32'(N + 1));
    check("f0_pushes", 32'(push_total - base_push), 32'(8));
    lasts = 0;
    for (int i = 0; i < 8 && base_push + i < push_total; i++) begin
      check("f0_push_data", 32'(push_data[base_push + i]), 32'(exp0[i]));
      lasts += int'(push_last[base_push + i]);
    end
    check("f0_last_count", 32'(lasts), 32'(1));
    if (push_total - base_push == 8) check("f0_last_on_21", 32'(push_last[base_push + 7]), 32'(1));
    check("f0_frame_count", 32'(frame_count), 32'(1));
`ifdef ROI_LOADER_ROI_COUNT_EN
    check("f0_roi_count", 32'(roi_count), 32'(8));
`endif

    // Output FIFO full: out-of-ROI pixels 0..9 pass, pixel 10 stalls.
    fifo_out_full = 1'b1;
    base_wr   = wr_total;
    base_push = push_total;
    push_frame(1, N);
    repeat (20) tick();
    check("stall_writes", 32'(wr_total - base_wr), 32'(10));
    check("stall_rd_en", 32'(in_rd_en), 32'(0));
    check("stall_bram_wr", 32'(bram_out_wr_en), 32'(0));
    fifo_out_full = 1'b0;
    wait_fin(2, 80, "stall_done", cyc);
    check("stall_total_writes", 32'(wr_total - base_wr), 32'(N));
    check("stall_pushes", 32'(push_total - base_push), 32'(8));
    check("stall_frame_count", 32'(frame_count), 32'(2));

    // Back-to-back frames; ROI widened mid-frame only affects the second.
    base_push = push_total;
    push_frame(2, N);
    push_frame(3, N);
    repeat (6) tick();
    set_roi(0, 7, 0, 3);
    wait_fin(3, 80, "b2b_f1_done", cyc);
    mid = push_total;
    check("b2b_f1_pushes", 32'(mid - base_push), 32'(8));
    wait_fin(4, 80, "b2b_f2_done", cyc);
    check("b2b_f2_cycles", 32'(cyc), 32'(N + 1));
    check("b2b_f2_pushes", 32'(push_total - mid), 32'(N));
    check("b2b_frame_count", 32'(frame_count), 32'(4));

    // Inverted column bounds: BRAM only.
    set_roi(5, 2, 1, 2);
    base_push = push_total;
    base_wr   = wr_total;
    push_frame(4, N);
    wait_fin(5, 80, "inv_done", cyc);
    check("inv_pushes", 32'(push_total - base_push), 32'(0));
    check("inv_writes", 32'(wr_total - base_wr), 32'(N));
    check("inv_frame_count", 32'(frame_count), 32'(5));
`ifdef ROI_LOADER_ROI_COUNT_EN
    check("inv_roi_count", 32'(roi_count), 32'(0));
`endif

    // Random empty gaps on the input FIFO.
    set_roi(2, 5, 1, 2);
    gap_en  = 1'b1;
    base_wr = wr_total;
    push_frame(5, N);
    wait_fin(6, 600, "gap_done", cyc);
    gap_en = 1'b0;
    drive();
    check("gap_writes", 32'(wr_total - base_wr), 32'(N));

    // Reset after pixel 12; the rest of the stream starts a new frame.
    base_wr = wr_total;
    push_frame(6, N);
    cyc = 0;
    while (wr_total - base_wr < 13 && cyc < 100) begin
      tick();
      cyc++;
    end
    check("pre_reset_writes", 32'(wr_total - base_wr), 32'(13));
    reset = 1'b1;
    #1;
    check("in_reset_rd_en", 32'(in_rd_en), 32'(0));
    check("in_reset_bram_wr", 32'(bram_out_wr_en), 32'(0));
    tick();
    reset = 1'b0;
    #1;
    check("after_reset_frame_count", 32'(frame_count), 32'(0));
    base_push = push_total;
    push_frame(7, 13);
    wait_fin(7, 80, "rst_frame_done", cyc);
    check("rst_frame_count", 32'(frame_count), 32'(1));
    check("rst_frame_pushes", 32'(push_total - base_push), 32'(8));
    if (push_total - base_push > 0)
      check("rst_first_push", 32'(push_data[base_push]), 32'(6 * 256 + 23));

    repeat (3) tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
